// File: rtl/traffic_start_ctrl_if.sv
// Request-path bundle between the light FSM side (master) and traffic_start_ctrl (slave).
// press_cnt exists only when TRAFFIC_PRESS_COUNT_EN is defined.
interface traffic_start_ctrl_if;
    logic       pow;
    logic       btn;
    logic [1:0] curst;
    logic       str;
    logic       pend;
`ifdef TRAFFIC_PRESS_COUNT_EN
    logic [7:0] press_cnt;
`endif

    modport master (
        output pow,
        output btn,
        output curst,
`ifdef TRAFFIC_PRESS_COUNT_EN
        input  press_cnt,
`endif
        input  str,
        input  pend
    );

    modport slave (
        input  pow,
        input  btn,
        input  curst,
`ifdef TRAFFIC_PRESS_COUNT_EN
        output press_cnt,
`endif
        output str,
        output pend
    );
endinterface

// File: rtl/traffic_start_ctrl.sv
// Button front-end for the traffic light FSM: sync, debounce, latch request, issue one-cycle STR.
// Optional request counter output enabled by defining TRAFFIC_PRESS_COUNT_EN.
module traffic_start_ctrl #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_GREEN       = 8,
    parameter int unsigned CNT_W           = 8
) (
    input logic                 clk,
    input logic                 rst,
    traffic_start_ctrl_if.slave bus
);

    localparam int unsigned CURST_W = 2;
    localparam logic [CURST_W-1:0] ST_GREEN = CURST_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] GREEN_MAX  = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIRE = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               str_d, pend_d;
    logic [CNT_W-1:0]   ack_q, ack_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   db_lvl_q;
    logic [CNT_W-1:0]       db_cnt_q;
    logic                   req_q;
    logic [CNT_W-1:0]       green_q;

    logic btn_s_c;
    logic db_hit_c;
    logic green_c;
    logic green_ok_c;

    assign btn_s_c    = sync_q[SYNC_STAGES-1];
    assign db_hit_c   = (btn_s_c != db_lvl_q) && ((db_cnt_q + CNT_ONE) == DB_LAST);
    assign green_c    = (bus.curst == ST_GREEN);
    assign green_ok_c = (green_q == GREEN_MAX);

    // Synchroniser, debouncer, request edge and green timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
            req_q    <= 1'b0;
            green_q  <= '0;
        end else if (!bus.pow) begin
            sync_q   <= '0;
            db_lvl_q <= 1'b0;
            db_cnt_q <= '0;
            req_q    <= 1'b0;
            green_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn};
            if (btn_s_c == db_lvl_q) begin
                db_cnt_q <= '0;
            end else if (db_hit_c) begin
                db_lvl_q <= btn_s_c;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + CNT_ONE;
            end
            // Only the debounced rising edge is a request; held buttons give one event.
            req_q <= db_hit_c && btn_s_c;
            if (!green_c) begin
                green_q <= '0;
            end else if (!green_ok_c) begin
                green_q <= green_q + CNT_ONE;
            end
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        ack_d   = '0;
        str_d   = 1'b0;
        pend_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (green_c && green_ok_c) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                state_d = S_ACK;
            end
            S_ACK: begin
                // Light left green: accepted. Still green after MIN_GREEN cycles: retry.
                if (!green_c) begin
                    state_d = S_IDLE;
                end else if (ack_q == ACK_LAST) begin
                    state_d = S_WAIT;
                end else begin
                    ack_d = ack_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        str_d  = (state_d == S_FIRE);
        pend_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ack_q    <= '0;
            bus.str  <= 1'b0;
            bus.pend <= 1'b0;
        end else if (!bus.pow) begin
            state_q  <= S_IDLE;
            ack_q    <= '0;
            bus.str  <= 1'b0;
            bus.pend <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            bus.str  <= str_d;
            bus.pend <= pend_d;
        end
    end

`ifdef TRAFFIC_PRESS_COUNT_EN
    // Accepted requests (IDLE->WAIT), saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.press_cnt <= 8'd0;
        end else if (!bus.pow) begin
            bus.press_cnt <= 8'd0;
        end else if ((state_q == S_IDLE) && req_q && (bus.press_cnt != 8'hFF)) begin
            bus.press_cnt <= bus.press_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_traffic_start_ctrl.sv
// Directed bench for traffic_start_ctrl: stimulus queues expected str/pend per cycle, monitor checks.
module tb_traffic_start_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    traffic_start_ctrl_if bus();

    traffic_start_ctrl #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .MIN_GREEN       (8),
        .CNT_W           (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic  str;
        logic  pend;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    logic prev_str = 1'b0;

    // One clock edge; the outputs after it must equal (s, p)
    task automatic tick(input logic s, input logic p, input string tag);
        exp_t e;
        @(posedge clk);
        e.str  = s;
        e.pend = p;
        e.tag  = tag;
        sb.push_back(e);
        #1;
    endtask

    task automatic run(input int n, input logic s, input logic p, input string tag);
        for (int i = 0; i < n; i++) tick(s, p, tag);
    endtask

    // Monitor: pop one expectation per cycle, and police STR pulse width
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cmp++;
            if (bus.str !== mon_e.str || bus.pend !== mon_e.pend) begin
                n_bad++;
                $display("FAIL %s @%0t: got str=%b pend=%b, want str=%b pend=%b",
                         mon_e.tag, $time, bus.str, bus.pend, mon_e.str, mon_e.pend);
            end
        end
        if (bus.str === 1'b1) begin
            n_cmp++;
            if (prev_str === 1'b1) begin
                n_bad++;
                $display("FAIL str_b2b @%0t: got str high two cycles, want single-cycle pulse", $time);
            end
        end
        prev_str = bus.str;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus, want finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        bus.pow   = 1'b0;
        bus.btn   = 1'b0;
        bus.curst = 2'b00;
        run(2, 1'b0, 1'b0, "reset");
        rst = 1'b0;

        // Powered off: button toggling is ignored
        for (int i = 0; i < 6; i++) begin
            bus.btn = i[0];
            tick(1'b0, 1'b0, "pow_off");
        end

        // Green held long, then press: STR 8 cycles after BTN rises
        bus.btn   = 1'b0;
        bus.pow   = 1'b1;
        bus.curst = 2'b01;
        run(20, 1'b0, 1'b0, "green_idle");
        bus.btn = 1'b1;
        run(6, 1'b0, 1'b0, "lat_sync");
        tick(1'b0, 1'b1, "lat_wait");
        tick(1'b1, 1'b1, "lat_fire");
        run(2, 1'b0, 1'b1, "lat_ack");
        bus.curst = 2'b10;
        tick(1'b0, 1'b0, "ack_leave");
        bus.btn = 1'b0;
        run(10, 1'b0, 1'b0, "release");

        // Three-cycle glitch never debounces
        bus.btn = 1'b1;
        run(3, 1'b0, 1'b0, "glitch_hi");
        bus.btn = 1'b0;
        run(8, 1'b0, 1'b0, "glitch_lo");

        // Request on red waits; fires only after MIN_GREEN green cycles
        bus.curst = 2'b11;
        bus.btn   = 1'b1;
        run(6, 1'b0, 1'b0, "red_sync");
        run(4, 1'b0, 1'b1, "red_wait");
        bus.curst = 2'b01;
        run(8, 1'b0, 1'b1, "green_count");
        tick(1'b1, 1'b1, "green_fire");

        // Light ignores STR: 8 cycles in ACK, back to WAIT, second pulse
        run(9, 1'b0, 1'b1, "ignored_ack");
        tick(1'b1, 1'b1, "retry_fire");
        tick(1'b0, 1'b1, "retry_ack");
        bus.curst = 2'b10;
        tick(1'b0, 1'b0, "retry_leave");

        // Power dropped in the FIRE cycle
        bus.btn   = 1'b0;
        bus.curst = 2'b01;
        run(10, 1'b0, 1'b0, "pow_prep");
        bus.btn = 1'b1;
        run(6, 1'b0, 1'b0, "pf_sync");
        tick(1'b0, 1'b1, "pf_wait");
        tick(1'b1, 1'b1, "pf_fire");
        bus.pow = 1'b0;
        bus.btn = 1'b0;
        tick(1'b0, 1'b0, "pf_drop");
        tick(1'b0, 1'b0, "pf_off");
        bus.pow = 1'b1;
        run(12, 1'b0, 1'b0, "pf_restore");
`ifdef TRAFFIC_PRESS_COUNT_EN
        n_cmp++;
        if (bus.press_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL press_clr: got %0d, want 0", bus.press_cnt);
        end
`endif

        // Fresh press after power restore works normally
        bus.btn = 1'b1;
        run(6, 1'b0, 1'b0, "new_sync");
        tick(1'b0, 1'b1, "new_wait");
        tick(1'b1, 1'b1, "new_fire");
        tick(1'b0, 1'b1, "new_ack");
        bus.curst = 2'b10;
        tick(1'b0, 1'b0, "new_leave");
`ifdef TRAFFIC_PRESS_COUNT_EN
        n_cmp++;
        if (bus.press_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL press_one: got %0d, want 1", bus.press_cnt);
        end
`endif

        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_start_ctrl.md
Name: traffic_start_ctrl

Overview:
Request front-end directly upstream of the traffic light FSM. It synchronises and debounces a raw request button, latches the request, and issues the light FSM's one-cycle STR pulse. STR fires only once green has been held MIN_GREEN cycles. The block consumes the light FSM's CURST to time green and detect acknowledgement.

Parameters:
SYNC_STAGES, 2, flops in the BTN synchroniser chain (min 2).
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed to change the debounced level (min 1).
MIN_GREEN, 8, cycles CURST must have been GREEN before STR may fire (min 1).
CNT_W, 8, width of the debounce and green counters; must hold max(DEBOUNCE_CYCLES, MIN_GREEN).

Ports:
CLK  in  1  system clock, rising edge.
RST  in  1  asynchronous, active-high reset.
POW  in  1  power enable, same net as light FSM POW; 0 = block held idle.
BTN  in  1  raw request button, asynchronous to CLK, active-high.
CURST  in  2  light FSM state: 00 OFF, 01 GREEN, 10 YELLOW, 11 RED.
STR  out  1  start pulse to light FSM, exactly one CLK cycle wide.
PEND  out  1  request latched and not yet acknowledged.

Behaviour:
- Reset (RST=1, async): STR=0, PEND=0, FSM=IDLE, all counters 0, synchroniser flops 0, debounced level 0.
- POW=0 (sync, checked every edge): same clear as reset. BTN is ignored while POW=0. Clear takes priority over all events in that cycle.
- Synchroniser: BTN passes through SYNC_STAGES flops, giving btn_s.
- Debounce:
  - Counter resets to 0 whenever btn_s equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES, the debounced level takes btn_s and the counter clears.
  - A debounced 0->1 transition is the only request event. Holding BTN high produces one event only.
- Green timer:
  - Clears in any cycle with CURST != 01.
  - Increments while CURST == 01 and saturates at MIN_GREEN. It does not wrap.
  - green_ok = (timer == MIN_GREEN).
- FSM (registered outputs):
  - IDLE: PEND=0, STR=0. On request event go to WAIT.
  - WAIT: PEND=1. If CURST==01 and green_ok, go to FIRE.
  - FIRE: STR=1 for this single cycle, PEND=1. Go unconditionally to ACK.
  - ACK: PEND=1, STR=0.
    - If CURST != 01, go to IDLE.
    - If CURST is still 01 after MIN_GREEN cycles in ACK (light ignored STR), go back to WAIT to retry. The ACK counter reuses the green counter width.
- Latency: with BTN stable high from cycle 0 and green_ok already true, the STR rising edge comes SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles after BTN rises. That is 8 cycles at the defaults.
- Request events arriving in WAIT, FIRE or ACK are absorbed; there is no queueing and no second pulse.
- A request while CURST is YELLOW, RED or OFF waits in WAIT until the next green satisfies green_ok.
- If CURST leaves 01 during WAIT, the timer clears and WAIT persists.
- Reset or POW=0 in FIRE: STR drops to 0 on the next edge (async for RST) and PEND clears.
- STR is never high for two consecutive cycles.

Optional Feature:
TRAFFIC_PRESS_COUNT_EN:
- When defined, adds output PRESS_CNT [7:0]. It counts request events accepted in IDLE (i.e. IDLE->WAIT transitions) and saturates at 255.
- PRESS_CNT is cleared by RST and by POW=0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- RST=1 for 2 cycles, then RST=0 with POW=0 and BTN toggling -> STR=0, PEND=0 throughout.
- POW=1, CURST=01 held 20 cycles, BTN high from cycle 20 -> STR=1 in exactly one cycle, 8 cycles after BTN rises. PEND=1 from the WAIT entry until CURST goes to 10, then 0.
- Glitch: BTN high for 3 cycles then low, with DEBOUNCE_CYCLES=4 -> no request event, PEND stays 0, STR stays 0.
- Request while CURST=11 -> PEND=1, no STR. Then CURST=01 -> STR fires at green cycle 8 (MIN_GREEN), not earlier.
- Light ignores STR (CURST stays 01) -> after 8 cycles in ACK the FSM returns to WAIT and a second STR pulse fires. No back-to-back STR.
- POW drops to 0 in the FIRE cycle -> STR=0 and PEND=0 next edge. After POW=1 again, no spurious STR until a new debounced press. With TRAFFIC_PRESS_COUNT_EN defined, PRESS_CNT reads 0.
